// File: rtl/ssm_pkg.sv
// Shared types and constants for the SSM y-reduction datapath.
package ssm_pkg;

  localparam int DW = 16;
  localparam logic [DW-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // Accept-to-result latency: add tree, accumulator adder, output register.
  function automatic int flush_lat(input int n_tile, input int a_lat);
    return $clog2(n_tile) * a_lat + a_lat + 1;
  endfunction

endpackage

// File: rtl/fp16_add_wrapper.sv
// FP16 adder (round-to-nearest-even, exact alignment) behind a fixed LAT-stage
// pipeline. No reset: tokens left in flight must be discarded by the consumer.
module fp16_add_wrapper #(
  parameter int LAT = 11
) (
  input  logic        clk,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        valid_out
);

  // Value scaled by 2^24 so every finite FP16 is an exact integer.
  function automatic logic signed [42:0] fp16_fixed(input logic [15:0] x);
    logic [42:0] m;
    int          e;
    m = {32'd0, (x[14:10] != 5'd0), x[9:0]};
    e = (x[14:10] == 5'd0) ? 0 : int'(x[14:10]) - 1;
    m = m << e;
    return x[15] ? -$signed(m) : $signed(m);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic               x_nan, y_nan, x_inf, y_inf, sgn, guard, sticky;
    logic signed [42:0] sum;
    logic [41:0]        mag;
    logic [10:0]        man;
    logic [11:0]        rnd;
    logic [5:0]         exp_r;
    int                 msb, sh;
    x_nan = (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
    y_nan = (y[14:10] == 5'h1f) && (y[9:0] != 10'd0);
    x_inf = (x[14:10] == 5'h1f) && (x[9:0] == 10'd0);
    y_inf = (y[14:10] == 5'h1f) && (y[9:0] == 10'd0);
    if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15]))) return 16'h7E00;
    if (x_inf) return x;
    if (y_inf) return y;
    sum = fp16_fixed(x) + fp16_fixed(y);
    if (sum == 43'sd0) return {x[15] & y[15], 15'd0};
    sgn = sum[42];
    mag = sgn ? 42'(-sum) : 42'(sum);
    msb = 0;
    for (int i = 0; i < 42; i++) if (mag[i]) msb = i;
    // Subnormal or smallest-normal results are exact: the bits are the encoding.
    if (msb <= 10) return {sgn, 4'd0, mag[10:0]};
    sh     = msb - 10;
    man    = 11'(mag >> sh);
    guard  = mag[sh-1];
    sticky = 1'b0;
    for (int i = 0; i < 41; i++) if (i < sh - 1) sticky = sticky | mag[i];
    rnd   = {1'b0, man} + 12'(guard && (sticky || man[0]));
    exp_r = 6'(sh + 1);
    if (rnd[11]) begin
      rnd   = rnd >> 1;
      exp_r = exp_r + 6'd1;
    end
    if (exp_r >= 6'd31) return {sgn, 5'h1f, 10'd0};
    return {sgn, exp_r[4:0], rnd[9:0]};
  endfunction

  logic [15:0]    sum_d;
  logic [15:0]    res_q [LAT];
  logic [LAT-1:0] vld_q;

  always_comb sum_d = fp16_add(a, b);

  always_ff @(posedge clk) begin
    res_q[0] <= sum_d;
    vld_q[0] <= valid_in;
    for (int i = 1; i < LAT; i++) begin
      res_q[i] <= res_q[i-1];
      vld_q[i] <= vld_q[i-1];
    end
  end

  assign result    = res_q[LAT-1];
  assign valid_out = vld_q[LAT-1];

endmodule

// File: rtl/y_add_tree.sv
// N_TILE-input pipelined FP16 add tree; level k pairs nodes (2i, 2i+1).
// Latency clog2(N_TILE)*A_LAT.
module y_add_tree
  import ssm_pkg::*;
#(
  parameter int N_TILE = 16,
  parameter int A_LAT  = 11
) (
  input  logic                 clk,
  input  logic                 valid_in,
  input  logic [N_TILE*DW-1:0] in_i,
  output logic [DW-1:0]        sum_o,
  output logic                 valid_out
);

  localparam int LV    = $clog2(N_TILE);
  localparam int NODES = 2 * N_TILE - 1;

  // Heap-style node store: level k starts at 2*N_TILE - 2*(N_TILE >> k).
  logic [NODES*DW-1:0] node;
  logic [NODES-1:0]    nvld;

  assign node[N_TILE*DW-1:0] = in_i;
  assign nvld[N_TILE-1:0]    = {N_TILE{valid_in}};

  for (genvar k = 0; k < LV; k++) begin : g_lvl
    for (genvar i = 0; i < (N_TILE >> (k + 1)); i++) begin : g_add
      localparam int SRC = 2 * N_TILE - 2 * (N_TILE >> k) + 2 * i;
      localparam int DST = 2 * N_TILE - 2 * (N_TILE >> (k + 1)) + i;
      fp16_add_wrapper #(.LAT(A_LAT)) u_add (
        .clk       (clk),
        .valid_in  (nvld[SRC] & nvld[SRC+1]),
        .a         (node[SRC*DW +: DW]),
        .b         (node[(SRC+1)*DW +: DW]),
        .result    (node[DST*DW +: DW]),
        .valid_out (nvld[DST])
      );
    end
  end

  assign sum_o     = node[(NODES-1)*DW +: DW];
  assign valid_out = nvld[NODES-1];

endmodule

// File: rtl/ssm_y_reduce.sv
// Reduces packed h*p*n FP16 products over n: per-beat add tree, then a
// cross-tile accumulator. Optional tile-count checking with Y_TILE_CHECK_EN.
module ssm_y_reduce
  import ssm_pkg::*;
#(
  parameter int H_TILE  = 1,
  parameter int P_TILE  = 1,
  parameter int N_TILE  = 16,
  parameter int N_TOTAL = 128,
  parameter int A_LAT   = 11
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic                               last_i,
  input  logic [H_TILE*P_TILE*N_TILE*DW-1:0] prod_i,
  output logic [H_TILE*P_TILE*DW-1:0]        y_o,
  output logic                               valid_o,
  output logic                               err_o,
  output state_t                             dbg_state_o
);

  localparam int HP = H_TILE * P_TILE;
  localparam int L  = flush_lat(N_TILE, A_LAT);
  localparam int CW = $clog2(L + 1);

  // Handshake: a beat transfers on a rising edge where valid_i && ready_o;
  // upstream holds prod_i/last_i stable while valid_i is high and ready_o low.

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic             valid_q, valid_d;
  logic [HP*DW-1:0] acc_q, acc_d, y_q, y_d;

  logic             accept, acc_launch, acc_done;
  logic [HP*DW-1:0] tree_sum, acc_b, acc_res;
  logic [HP-1:0]    tree_vld_v, acc_vld_v;

  assign accept     = valid_i && ready_o;
  assign acc_launch = (&tree_vld_v) && (state_q == BUSY);
  assign acc_done   = (&acc_vld_v) && (state_q == BUSY);
  // First tile adds +0.0 so a -0 tile sum comes out as +0.
  assign acc_b      = first_q ? {HP{FP16_ZERO}} : acc_q;

  for (genvar j = 0; j < HP; j++) begin : g_lane
    y_add_tree #(.N_TILE(N_TILE), .A_LAT(A_LAT)) u_tree (
      .clk       (clk),
      .valid_in  (accept),
      .in_i      (prod_i[j*N_TILE*DW +: N_TILE*DW]),
      .sum_o     (tree_sum[j*DW +: DW]),
      .valid_out (tree_vld_v[j])
    );
    fp16_add_wrapper #(.LAT(A_LAT)) u_acc (
      .clk       (clk),
      .valid_in  (acc_launch),
      .a         (tree_sum[j*DW +: DW]),
      .b         (acc_b[j*DW +: DW]),
      .result    (acc_res[j*DW +: DW]),
      .valid_out (acc_vld_v[j])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FLUSH;
      cnt_q   <= CW'(L);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FLUSH: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_d = IDLE;
      end
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (acc_done) state_d = IDLE;
      default: state_d = FLUSH;
    endcase
  end

  always_comb begin
    ready_o     = (state_q == IDLE);
    dbg_state_o = state_q;
  end

  always_comb begin
    last_d  = accept ? last_i : last_q;
    first_d = first_q;
    acc_d   = acc_q;
    y_d     = y_q;
    valid_d = 1'b0;
    if (acc_done) begin
      acc_d   = acc_res;
      first_d = 1'b0;
      if (last_q) begin
        y_d     = acc_res;
        valid_d = 1'b1;
        first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q  <= 1'b0;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      last_q  <= last_d;
      first_q <= first_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;

`ifdef Y_TILE_CHECK_EN
  localparam int NT = N_TOTAL / N_TILE;
  localparam int TW = $clog2(NT + 1) + 1;

  logic [TW-1:0] tile_q, tile_d, tile_inc;
  logic          err_q, err_d;

  always_comb begin
    tile_inc = tile_q + 1'b1;
    tile_d   = tile_q;
    err_d    = err_q;
    if (accept) begin
      if (last_i) begin
        tile_d = '0;
        if (tile_inc != TW'(NT)) err_d = 1'b1;
      end else begin
        tile_d = tile_inc;
        if (tile_inc == TW'(NT)) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tile_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tile_q <= tile_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ssm_y_reduce.sv
// Directed bench for ssm_y_reduce with N_TILE=4, N_TOTAL=8 (L = 2*11+11+1 = 34).
module tb_ssm_y_reduce;
  import ssm_pkg::*;

  localparam int NT = 4;
  localparam int W  = 16;
  localparam int L  = 34;
`ifdef Y_TILE_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic [NT*W-1:0] prod_i = '0;
  logic          ready_o, valid_o, err_o;
  logic [W-1:0]  y_o;
  state_t        dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_acc = 0;
  int cnt, v0, a0;
  logic [W-1:0] exp_q[$];

  ssm_y_reduce #(
    .H_TILE(1), .P_TILE(1), .N_TILE(NT), .N_TOTAL(8), .A_LAT(11)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .last_i      (last_i),
    .prod_i      (prod_i),
    .y_o         (y_o),
    .valid_o     (valid_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (valid_o) n_valid++;
    if (rstn && valid_i && ready_o) n_acc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT*W-1:0] fill(input logic [W-1:0] v);
    return {NT{v}};
  endfunction

  // driver tasks
  task automatic send(input logic [NT*W-1:0] d, input logic last, input logic [W-1:0] exp_y);
    int i;
    i = 0;
    while (!ready_o && i < 2 * L) begin
      @(negedge clk);
      i++;
    end
    check("ready_wait", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    prod_i  = d;
    last_i  = last;
    if (last) exp_q.push_back(exp_y);
    @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // scoreboard: called on the negedge just after the last beat was accepted
  task automatic wait_result(input string tag);
    int lat;
    logic [W-1:0] e;
    lat = 1;
    while (!valid_o && lat < 2 * L) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(L));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    check({tag, "_y"}, 32'(y_o), 32'(e));
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(valid_o), 32'd0);
    check({tag, "_hold"}, 32'(y_o), 32'(e));
  endtask

  task automatic measure_flush(input string tag);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!ready_o && i < 2 * L);
    check(tag, 32'(i), 32'(L));
  endtask

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_y", 32'(y_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(FLUSH));
    rstn = 1'b1;
    measure_flush("flush_len");

    // two beats of 1.0 -> 8.0
    v0 = n_valid;
    send(fill(16'h3C00), 1'b0, 16'h0000);
    cnt = 0;
    while (!ready_o && cnt < 2 * L) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_gap", 32'(cnt), 32'(L - 1));
    check("no_mid_valid", 32'(n_valid), 32'(v0));
    send(fill(16'h3C00), 1'b1, 16'h4800);
    wait_result("ones");
    check("ones_count", 32'(n_valid), 32'(v0 + 1));
    check("ones_err", 32'(err_o), 32'd0);

    // cancellation in the tree, then a zero tile
    send({16'h3800, 16'h3800, 16'hC000, 16'h4000}, 1'b0, 16'h0000);
    send(fill(16'h0000), 1'b1, 16'h3C00);
    wait_result("mixed");

    // -0 tiles: first tile adds +0, result is +0
    send(fill(16'h8000), 1'b0, 16'h0000);
    send(fill(16'h8000), 1'b1, 16'h0000);
    wait_result("negzero");

    // valid_i held high across two beats
    a0 = n_acc;
    valid_i = 1'b1;
    prod_i  = fill(16'h3C00);
    last_i  = 1'b0;
    exp_q.push_back(16'h4A00);
    @(negedge clk);
    prod_i = fill(16'h4000);
    last_i = 1'b1;
    cnt = 0;
    while (!ready_o && cnt < 2 * L) begin
      cnt++;
      @(negedge clk);
    end
    check("held_gap", 32'(cnt), 32'(L - 1));
    @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
    wait_result("held");
    check("held_accepts", 32'(n_acc - a0), 32'd2);

    // reset 5 cycles into BUSY
    v0 = n_valid;
    send(fill(16'h3C00), 1'b0, 16'h0000);
    repeat (4) @(negedge clk);
    check("pre_rst_state", 32'(dbg_state_o), 32'(BUSY));
    rstn = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_o), 32'd0);
    check("midrst_state", 32'(dbg_state_o), 32'(FLUSH));
    check("midrst_y", 32'(y_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    measure_flush("reflush_len");
    check("midrst_no_valid", 32'(n_valid), 32'(v0));
    send(fill(16'h3C00), 1'b0, 16'h0000);
    send(fill(16'h3C00), 1'b1, 16'h4800);
    wait_result("post_rst");
    check("post_rst_count", 32'(n_valid), 32'(v0 + 1));
    check("post_rst_err", 32'(err_o), 32'd0);

    // last on beat 1 -> tile-count error when checking is built in
    send(fill(16'h3C00), 1'b1, 16'h4400);
    check("early_last_err", 32'(err_o), 32'(ERR_EN));
    wait_result("early_last");
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err_o), 32'(ERR_EN));

    // three beats without last -> error at beat 2
    rstn = 1'b0;
    @(negedge clk);
    check("err_rst", 32'(err_o), 32'd0);
    rstn = 1'b1;
    measure_flush("flush3");
    send(fill(16'h3C00), 1'b0, 16'h0000);
    check("nolast_b1_err", 32'(err_o), 32'd0);
    send(fill(16'h3C00), 1'b0, 16'h0000);
    check("nolast_b2_err", 32'(err_o), 32'(ERR_EN));
    send(fill(16'h3C00), 1'b0, 16'h0000);
    check("nolast_b3_err", 32'(err_o), 32'(ERR_EN));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
